// File: rtl/code_entry_ctrl.sv
// code_entry_ctrl: press-driven combination-lock sequencer driving six active-low HEX displays.
// Define CODE_LOCKOUT_EN to build the timed lockout after MAX_FAIL consecutive failures.
module code_entry_ctrl #(
  parameter logic [23:0] CODE           = 24'h281996,
  parameter int          MAX_FAIL       = 3,
  parameter int          LOCKOUT_CYCLES = 50_000_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       enter,
  input  logic       clear,
  output logic [6:0] H1,
  output logic [6:0] H2,
  output logic [6:0] H3,
  output logic [6:0] H4,
  output logic [6:0] H5,
  output logic [6:0] H6,
  output logic       unlocked,
  output logic       lockout,
  output logic [1:0] fail_count
);

  if (MAX_FAIL < 1 || MAX_FAIL > 3 || LOCKOUT_CYCLES < 2) begin : g_bad_params
    $error("code_entry_ctrl: parameter out of range");
  end

  localparam logic [1:0] MAX_Q = 2'(MAX_FAIL);

  typedef enum logic [2:0] {
    ENTRY0,
    ENTRY1,
    ENTRY2,
    CHECK,
    PASS,
    FAIL
`ifdef CODE_LOCKOUT_EN
    , LOCKOUT
`endif
  } state_t;

  state_t          state_q, state_d;
  logic [2:0][7:0] slot_q, slot_d;
  logic [2:0]      valid_q, valid_d;
  logic            enter_q, enter_d;
  logic [1:0]      fail_q, fail_d, fail_inc;
  logic            unlocked_q, unlocked_d;
  logic            enter_rise;

`ifdef CODE_LOCKOUT_EN
  localparam int TW = $clog2(LOCKOUT_CYCLES + 1);
  logic [TW-1:0] timer_q, timer_d;
  logic          lockout_q, lockout_d;
`endif

  assign enter_d    = enter;
  assign enter_rise = enter & ~enter_q;

  always_comb begin
    state_d  = state_q;
    slot_d   = slot_q;
    valid_d  = valid_q;
    fail_d   = fail_q;
    fail_inc = (fail_q >= MAX_Q) ? MAX_Q : fail_q + 2'd1;
`ifdef CODE_LOCKOUT_EN
    timer_d  = timer_q;
`endif
    case (state_q)
      ENTRY0: begin
        if (clear) begin
          state_d = ENTRY0;
        end else if (enter_rise) begin
          slot_d[0]  = {A, B};
          valid_d[0] = 1'b1;
          state_d    = ENTRY1;
        end
      end
      ENTRY1: begin
        if (clear) begin
          state_d = ENTRY0;
        end else if (enter_rise) begin
          slot_d[1]  = {A, B};
          valid_d[1] = 1'b1;
          state_d    = ENTRY2;
        end
      end
      ENTRY2: begin
        if (clear) begin
          state_d = ENTRY0;
        end else if (enter_rise) begin
          slot_d[2]  = {A, B};
          valid_d[2] = 1'b1;
          state_d    = CHECK;
        end
      end
      CHECK: begin
        if ({slot_q[0], slot_q[1], slot_q[2]} == CODE) begin
          state_d = PASS;
          fail_d  = '0;
        end else begin
          fail_d  = fail_inc;
          state_d = FAIL;
`ifdef CODE_LOCKOUT_EN
          if (fail_inc == MAX_Q) begin
            state_d = LOCKOUT;
            timer_d = TW'(LOCKOUT_CYCLES - 1);
          end
`endif
        end
      end
      PASS: begin
        if (clear) state_d = ENTRY0;
      end
      FAIL: begin
        if (clear || enter_rise) state_d = ENTRY0;
      end
`ifdef CODE_LOCKOUT_EN
      LOCKOUT: begin
        if (timer_q == '0) begin
          state_d = ENTRY0;
          fail_d  = '0;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
`endif
      default: state_d = ENTRY0;
    endcase
    // ENTRY0 always holds an empty entry, so clearing here covers every way in.
    if (state_d == ENTRY0) valid_d = '0;
  end

  assign unlocked_d = (state_d == PASS);
`ifdef CODE_LOCKOUT_EN
  assign lockout_d  = (state_d == LOCKOUT);
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ENTRY0;
      slot_q     <= '0;
      valid_q    <= '0;
      enter_q    <= 1'b1;
      fail_q     <= '0;
      unlocked_q <= 1'b0;
`ifdef CODE_LOCKOUT_EN
      timer_q    <= '0;
      lockout_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      slot_q     <= slot_d;
      valid_q    <= valid_d;
      enter_q    <= enter_d;
      fail_q     <= fail_d;
      unlocked_q <= unlocked_d;
`ifdef CODE_LOCKOUT_EN
      timer_q    <= timer_d;
      lockout_q  <= lockout_d;
`endif
    end
  end

  assign unlocked   = unlocked_q;
  assign fail_count = fail_q;
`ifdef CODE_LOCKOUT_EN
  assign lockout    = lockout_q;
`else
  assign lockout    = 1'b0;
`endif

  function automatic logic [6:0] hex_font(input logic [3:0] d);
    logic [6:0] f;
    case (d)
      4'h0: f = 7'h3F;  4'h1: f = 7'h06;  4'h2: f = 7'h5B;  4'h3: f = 7'h4F;
      4'h4: f = 7'h66;  4'h5: f = 7'h6D;  4'h6: f = 7'h7D;  4'h7: f = 7'h07;
      4'h8: f = 7'h7F;  4'h9: f = 7'h67;  4'hA: f = 7'h77;  4'hB: f = 7'h7C;
      4'hC: f = 7'h39;  4'hD: f = 7'h5E;  4'hE: f = 7'h79;  default: f = 7'h71;
    endcase
    return f;
  endfunction

  // Active-high segment pattern; result states override the captured digits.
  function automatic logic [6:0] seg_on(input state_t st, input logic vld, input logic [3:0] nib);
    logic [6:0] seg;
    case (st)
      PASS:    seg = 7'h06;
      FAIL:    seg = 7'h40;
`ifdef CODE_LOCKOUT_EN
      LOCKOUT: seg = 7'h40;
`endif
      default: seg = vld ? hex_font(nib) : 7'h00;
    endcase
    return seg;
  endfunction

  logic [5:0][6:0] hex_n;

  for (genvar gi = 0; gi < 6; gi++) begin : g_digit
    localparam int SLOT = gi / 2;
    logic [3:0] nib;
    assign nib       = (gi % 2 == 0) ? slot_q[SLOT][7:4] : slot_q[SLOT][3:0];
    assign hex_n[gi] = ~seg_on(state_q, valid_q[SLOT], nib);
  end

  assign H1 = hex_n[0];
  assign H2 = hex_n[1];
  assign H3 = hex_n[2];
  assign H4 = hex_n[3];
  assign H5 = hex_n[4];
  assign H6 = hex_n[5];

endmodule

// File: tb/tb_code_entry_ctrl.sv
// Bench for code_entry_ctrl: directed and randomized presses checked every cycle against
// a queue-based model of the lock; follows CODE_LOCKOUT_EN the same way the design does.
`timescale 1ns/1ps
module tb_code_entry_ctrl;
  localparam logic [23:0] CODE     = 24'h281996;
  localparam int          MAX_FAIL = 3;
  localparam int          LOCK_CYC = 10;
`ifdef CODE_LOCKOUT_EN
  localparam bit          LOCK_EN  = 1'b1;
`else
  localparam bit          LOCK_EN  = 1'b0;
`endif
  localparam logic [6:0] FONT [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                       7'h7F, 7'h67, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] A = '0, B = '0;
  logic       enter = 1'b1, clear = 1'b0;
  logic [6:0] H1, H2, H3, H4, H5, H6;
  logic       unlocked, lockout;
  logic [1:0] fail_count;

  int vectors = 0;
  int miscompares = 0;

  code_entry_ctrl #(.CODE(CODE), .MAX_FAIL(MAX_FAIL), .LOCKOUT_CYCLES(LOCK_CYC)) dut (
    .clock(clock), .reset(reset), .A(A), .B(B), .enter(enter), .clear(clear),
    .H1(H1), .H2(H2), .H3(H3), .H4(H4), .H5(H5), .H6(H6),
    .unlocked(unlocked), .lockout(lockout), .fail_count(fail_count)
  );

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Reference model: pairs typed so far, the pending verdict and the outcome being shown.
  typedef enum {R_NONE, R_PASS, R_BAD, R_LOCK} res_t;
  res_t         m_res;
  byte unsigned m_slots[$];
  bit           m_check, m_prev;
  int           m_fails, m_lock_left;

  function automatic void model_reset();
    m_res = R_NONE; m_slots = {}; m_check = 1'b0; m_prev = 1'b1;
    m_fails = 0; m_lock_left = 0;
  endfunction

  function automatic void model_edge(input logic en, input logic cl, input logic [3:0] a, input logic [3:0] b);
    bit rise;
    rise   = en && !m_prev;
    m_prev = en;
    if (m_check) begin
      m_check = 1'b0;
      if ({m_slots[0], m_slots[1], m_slots[2]} == CODE) begin
        m_res = R_PASS; m_fails = 0;
      end else begin
        if (m_fails < MAX_FAIL) m_fails++;
        if (LOCK_EN && m_fails == MAX_FAIL) begin
          m_res = R_LOCK; m_lock_left = LOCK_CYC;
        end else begin
          m_res = R_BAD;
        end
      end
    end else if (m_res == R_LOCK) begin
      m_lock_left--;
      if (m_lock_left == 0) begin m_res = R_NONE; m_fails = 0; m_slots = {}; end
    end else if (m_res == R_PASS) begin
      if (cl) begin m_res = R_NONE; m_slots = {}; end
    end else if (m_res == R_BAD) begin
      if (cl || rise) begin m_res = R_NONE; m_slots = {}; end
    end else begin
      if (cl) m_slots = {};
      else if (rise) begin
        m_slots.push_back({a, b});
        if (m_slots.size() == 3) m_check = 1'b1;
      end
    end
  endfunction

  function automatic logic [6:0] exp_h(input int i);
    byte unsigned s;
    logic [3:0]   nib;
    if (m_res == R_PASS) return 7'h79;
    if (m_res == R_BAD || m_res == R_LOCK) return 7'h3F;
    if (i / 2 >= m_slots.size()) return 7'h7F;
    s   = m_slots[i / 2];
    nib = (i % 2 == 0) ? s[7:4] : s[3:0];
    return ~FONT[nib];
  endfunction

  task automatic check_all(input string tag);
    logic [41:0] obs_h, exp_hv;
    obs_h  = {H1, H2, H3, H4, H5, H6};
    exp_hv = {exp_h(0), exp_h(1), exp_h(2), exp_h(3), exp_h(4), exp_h(5)};
    vectors++;
    assert (obs_h === exp_hv) else begin
      miscompares++; $error("FAIL %s.hex observed=%h expected=%h", tag, obs_h, exp_hv);
    end
    vectors++;
    assert (unlocked === (m_res == R_PASS)) else begin
      miscompares++; $error("FAIL %s.unlocked observed=%b expected=%b", tag, unlocked, m_res == R_PASS);
    end
    vectors++;
    assert (lockout === (m_res == R_LOCK)) else begin
      miscompares++; $error("FAIL %s.lockout observed=%b expected=%b", tag, lockout, m_res == R_LOCK);
    end
    vectors++;
    assert (fail_count === 2'(m_fails)) else begin
      miscompares++; $error("FAIL %s.fail_count observed=%0d expected=%0d", tag, fail_count, m_fails);
    end
  endtask

  task automatic cyc(input logic en, input logic cl, input logic [3:0] a, input logic [3:0] b, input string tag);
    enter = en; clear = cl; A = a; B = b;
    @(posedge clock);
    model_edge(en, cl, a, b);
    #1;
    check_all(tag);
  endtask

  task automatic press(input logic [3:0] a, input logic [3:0] b, input string tag);
    cyc(1'b1, 1'b0, a, b, tag);
    cyc(1'b0, 1'b0, a, b, tag);
  endtask

  // Three presses (random hold length) followed by the verdict cycle.
  task automatic enter3(input logic [23:0] code, input string tag);
    logic [7:0] pr;
    int hold;
    for (int s = 0; s < 3; s++) begin
      pr   = code[23 - 8 * s -: 8];
      hold = $urandom_range(1, 3);
      for (int h = 0; h < hold; h++) cyc(1'b1, 1'b0, pr[7:4], pr[3:0], tag);
      cyc(1'b0, 1'b0, pr[7:4], pr[3:0], tag);
    end
    cyc(1'b0, 1'b0, 4'h0, 4'h0, tag);
  endtask

  task automatic attempt(input logic [23:0] code, input string tag);
    string outcome;
    enter3(code, tag);
    outcome = (m_res == R_PASS) ? "pass" : (m_res == R_LOCK) ? "lockout" :
              (m_res == R_BAD) ? "fail" : "none";
    $display("attempt %-10s code=%h outcome=%s fail_count=%0d", tag, code, outcome, fail_count);
    for (int k = 0; k < LOCK_CYC + 4 && m_res == R_LOCK; k++)
      cyc($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 4'($urandom), 4'($urandom), "lock_wait");
    if (m_res == R_PASS) begin
      press(4'h1, 4'h1, "pass_hold");
    end else if (m_res == R_BAD && $urandom_range(0, 1) == 1) begin
      press(4'h0, 4'h0, "bad_ack");
    end
    cyc(1'b0, 1'b1, 4'h0, 4'h0, "ack_clear");
    cyc(1'b0, 1'b0, 4'h0, 4'h0, "idle");
  endtask

  logic [23:0] rcode;
  logic [7:0]  rpair;
  int          k_idx;

  initial begin
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check_all("reset");
    reset = 1'b0;
    // enter was high through reset release: no capture
    cyc(1'b1, 1'b0, 4'h2, 4'h8, "held_reset");
    cyc(1'b1, 1'b0, 4'h2, 4'h8, "held_reset");
    cyc(1'b0, 1'b0, 4'h2, 4'h8, "held_reset");

    attempt(CODE, "correct");
    for (int n = 0; n < 4; n++) attempt(24'h281997, "wrong");

    press(4'h2, 4'h8, "clr_capture");
    cyc(1'b0, 1'b1, 4'h0, 4'h0, "clr_after1");
    cyc(1'b0, 1'b0, 4'h0, 4'h0, "clr_idle");
    cyc(1'b1, 1'b1, 4'h5, 4'h5, "enter_clear");
    cyc(1'b0, 1'b0, 4'h5, 4'h5, "enter_clear");
    for (int h = 0; h < 5; h++) cyc(1'b1, 1'b0, 4'h3, 4'h4, "held5");
    cyc(1'b0, 1'b0, 4'h3, 4'h4, "held5_rel");
    cyc(1'b0, 1'b1, 4'h0, 4'h0, "held5_clr");

    for (int n = 0; n < 20; n++) begin
      case ($urandom_range(0, 2))
        0:       rcode = CODE;
        1:       rcode = CODE ^ (24'h1 << (4 * $urandom_range(0, 5)));
        default: rcode = 24'($urandom);
      endcase
      attempt(rcode, "random");
    end

    for (int n = 0; n < 300; n++) begin
      k_idx = (m_slots.size() < 3) ? m_slots.size() : 0;
      rpair = ($urandom_range(0, 1) == 1) ? CODE[23 - 8 * k_idx -: 8] : 8'($urandom);
      cyc($urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0, rpair[7:4], rpair[3:0], "free_run");
    end
    cyc(1'b0, 1'b1, 4'h0, 4'h0, "free_end");
    for (int k = 0; k < LOCK_CYC + 2 && m_res != R_NONE; k++) cyc(1'b0, 1'b1, 4'h0, 4'h0, "free_end");

    for (int n = 0; n < 4 && m_res != R_LOCK; n++) begin
      enter3(24'h123456, "to_lock");
      if (m_res == R_BAD) cyc(1'b0, 1'b1, 4'h0, 4'h0, "to_lock_ack");
    end
    cyc(1'b1, 1'b0, 4'h0, 4'h0, "mid_lock");
    cyc(1'b1, 1'b0, 4'h0, 4'h0, "mid_lock");
    #2 reset = 1'b1;
    model_reset();
    #1 check_all("reset_mid_lock");
    @(posedge clock);
    #1 check_all("reset_held");
    reset = 1'b0;
    cyc(1'b1, 1'b0, 4'h9, 4'h9, "after_reset");
    press(4'h2, 4'h8, "after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
